if_id_inst_buffer: RTL

- Instruction buffer between instruction fetch and the decode stage.
- Accepts fetched {pc, inst, adef exception flag} with a valid/allowin handshake.
- Holds up to DEPTH entries in order and presents the head entry to decode, which feeds the instruction-sign producer.
- Decouples fetch stalls from decode stalls. A redirect flush from execute discards all buffered instructions.

---
 rtl/if_id_inst_buffer_pkg.sv | 19 +
 rtl/inst_buf_ram.sv | 29 ++
 rtl/if_id_inst_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/if_id_inst_buffer_pkg.sv
// Widths and bus layout for the fetch -> instruction buffer -> decode path.
// The bus is packed as {pc, inst, adef} with adef in the least significant bit.
package if_id_inst_buffer_pkg;

  localparam int IB_PC_W        = 32;
  localparam int IB_INST_W      = 32;
  localparam int FS_TO_IB_BUS_W = IB_PC_W + IB_INST_W + 1;
  localparam int IB_TO_DS_BUS_W = FS_TO_IB_BUS_W;

  localparam int IB_ADEF_OFS = 0;
  localparam int IB_INST_OFS = 1;
  localparam int IB_PC_OFS   = IB_INST_W + 1;

  // The pc field starts right above the instruction word.
  function automatic int pc_ofs(input int inst_w);
    return inst_w + 1;
  endfunction

endpackage

// File: rtl/inst_buf_ram.sv
// Register array that holds the buffered entries.
// Writes happen on the clock edge; the read port is combinational.
module inst_buf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_inst_buffer.sv
// In-order instruction buffer between fetch and decode.
// Pointers, occupancy, handshake and flush logic; storage lives in inst_buf_ram.
module if_id_inst_buffer
  import if_id_inst_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = IB_PC_W,
  parameter int INST_W = IB_INST_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs_to_ib_valid,
  output logic              ib_allowin,
  input  logic [PC_W-1:0]   fs_pc,
  input  logic [INST_W-1:0] fs_inst,
  input  logic              fs_adef,
  output logic              ib_to_ds_valid,
  input  logic              ds_allowin,
  output logic [PC_W-1:0]   ds_pc,
  output logic [INST_W-1:0] ds_inst,
  output logic              ds_adef,
  input  logic              flush,
  output logic [CW-1:0]     ib_count
);

  localparam int BUS_W              = PC_W + INST_W + 1;
  localparam int PC_OFS             = pc_ofs(INST_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             empty;
  logic [BUS_W-1:0] fs_bus;
  logic [BUS_W-1:0] ds_bus;

  assign empty          = (count == '0);
  assign ib_allowin     = (count != FULL_CNT) & ~flush;
  assign ib_to_ds_valid = ~empty & ~flush;
  assign push           = fs_to_ib_valid & ib_allowin;
  assign pop            = ib_to_ds_valid & ds_allowin;

  assign fs_bus = {fs_pc, fs_inst, fs_adef};

  inst_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (fs_bus),
    .raddr (rd_ptr),
    .rdata (ds_bus)
  );

  // Empty buffer presents zeros so stale storage never leaks to decode.
  assign ds_pc   = empty ? '0   : ds_bus[PC_OFS +: PC_W];
  assign ds_inst = empty ? '0   : ds_bus[IB_INST_OFS +: INST_W];
  assign ds_adef = empty ? 1'b0 : ds_bus[IB_ADEF_OFS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ib_count = count;

endmodule
